// File: rtl/core_ctrl_fsm_pkg.sv
// Shared definitions for the core control sequencer: state encodings and default MEM timeout.
// Optional CORE_CTRL_PERF_EN adds performance counters in the top module.
package core_ctrl_fsm_pkg;

    typedef enum logic [2:0] {
        CTRL_IDLE   = 3'd0,
        CTRL_FETCH  = 3'd1,
        CTRL_DECODE = 3'd2,
        CTRL_EXEC   = 3'd3,
        CTRL_MEM    = 3'd4,
        CTRL_WB     = 3'd5,
        CTRL_HALT   = 3'd6,
        CTRL_ERR    = 3'd7
    } ctrl_state_e;

    localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;
    localparam int unsigned WDOG_W              = 16;

endpackage

// File: rtl/core_ctrl_fsm_mem_watchdog.sv
// Memory-access watchdog: counts enabled cycles since the last clear and pulses timeout
// on the cycle whose increment would reach the limit.
module mem_watchdog
    import core_ctrl_fsm_pkg::*;
#(
    parameter int unsigned LIMIT_W = WDOG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [LIMIT_W-1:0] limit,
    output logic               timeout
);

    logic [LIMIT_W-1:0] count_q;
    logic [LIMIT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + LIMIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires while the count is one short of the limit, so this cycle's miss reaches it.
    assign timeout = en && (count_q == (limit - LIMIT_W'(1)));

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with ebreak halt and MEM timeout trap.
// Define CORE_CTRL_PERF_EN to add perf_cycles / perf_instret counters.
module core_ctrl_fsm
    import core_ctrl_fsm_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
`ifdef CORE_CTRL_PERF_EN
    , parameter int unsigned PERF_W = 64
`endif
) (
    input  logic       clk,
    input  logic       rst,
    output logic       ifu_req,
    input  logic       ifu_valid,
    output logic       inst_we,
    input  logic       dec_mem_read,
    input  logic       dec_mem_write,
    input  logic       dec_reg_write,
    input  logic       dec_ebreak,
    output logic       exu_en,
    output logic       lsu_req,
    output logic       lsu_wen,
    input  logic       lsu_done,
    output logic       rf_we,
    output logic       pc_we,
    output logic       halted,
    output logic       mem_err,
    output logic [2:0] state_o
`ifdef CORE_CTRL_PERF_EN
    , output logic [PERF_W-1:0] perf_cycles,
    output logic [PERF_W-1:0] perf_instret
`endif
);

    localparam logic [WDOG_W-1:0] TIMEOUT_LIM = WDOG_W'(MEM_TIMEOUT);

    ctrl_state_e state_q, state_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        reg_write_q, reg_write_d;
    logic        ebreak_q, ebreak_d;
    logic        wd_clr, wd_en, mem_timeout;

    assign wd_clr = (state_q != CTRL_MEM);
    assign wd_en  = (state_q == CTRL_MEM) && !lsu_done;

    mem_watchdog #(.LIMIT_W(WDOG_W)) u_mem_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .limit   (TIMEOUT_LIM),
        .timeout (mem_timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CTRL_IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
            ebreak_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            reg_write_q <= reg_write_d;
            ebreak_q    <= ebreak_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        reg_write_d = reg_write_q;
        ebreak_d    = ebreak_q;
        case (state_q)
            CTRL_IDLE:  state_d = CTRL_FETCH;
            CTRL_FETCH: if (ifu_valid) state_d = CTRL_DECODE;
            CTRL_DECODE: begin
                mem_read_d  = dec_mem_read;
                mem_write_d = dec_mem_write;
                reg_write_d = dec_reg_write;
                ebreak_d    = dec_ebreak;
                state_d     = CTRL_EXEC;
            end
            CTRL_EXEC: begin
                if (ebreak_q)                       state_d = CTRL_HALT;
                else if (mem_read_q || mem_write_q) state_d = CTRL_MEM;
                else                                state_d = CTRL_WB;
            end
            // lsu_done is checked first so a completion on the limit cycle still retires.
            CTRL_MEM: begin
                if (lsu_done)         state_d = CTRL_WB;
                else if (mem_timeout) state_d = CTRL_ERR;
            end
            CTRL_WB:  state_d = CTRL_FETCH;
            default:  state_d = state_q;
        endcase
    end

    always_comb begin
        ifu_req = 1'b0;
        inst_we = 1'b0;
        exu_en  = 1'b0;
        lsu_req = 1'b0;
        lsu_wen = 1'b0;
        rf_we   = 1'b0;
        pc_we   = 1'b0;
        halted  = 1'b0;
        mem_err = 1'b0;
        case (state_q)
            CTRL_FETCH: begin
                ifu_req = 1'b1;
                inst_we = ifu_valid;
            end
            CTRL_EXEC: exu_en = 1'b1;
            CTRL_MEM: begin
                lsu_req = 1'b1;
                lsu_wen = mem_write_q;
            end
            CTRL_WB: begin
                rf_we = reg_write_q;
                pc_we = 1'b1;
            end
            CTRL_HALT: halted  = 1'b1;
            CTRL_ERR:  mem_err = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state_q;

`ifdef CORE_CTRL_PERF_EN
    logic [PERF_W-1:0] perf_cycles_q, perf_cycles_d;
    logic [PERF_W-1:0] perf_instret_q, perf_instret_d;

    always_comb begin
        perf_cycles_d  = perf_cycles_q;
        perf_instret_d = perf_instret_q;
        if (state_q != CTRL_HALT && state_q != CTRL_ERR) begin
            perf_cycles_d = perf_cycles_q + PERF_W'(1);
        end
        if (state_q == CTRL_WB) begin
            perf_instret_d = perf_instret_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles_q  <= '0;
            perf_instret_q <= '0;
        end else begin
            perf_cycles_q  <= perf_cycles_d;
            perf_instret_q <= perf_instret_d;
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_instret = perf_instret_q;
`endif

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Bench for core_ctrl_fsm: per-instruction descriptors are expanded into expected per-cycle
// records (state + outputs) from the sequencing rules, then applied and compared cycle by cycle.
module tb_core_ctrl_fsm;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ifu_req, ifu_valid, inst_we;
    logic       dec_mem_read, dec_mem_write, dec_reg_write, dec_ebreak;
    logic       exu_en, lsu_req, lsu_wen, lsu_done;
    logic       rf_we, pc_we, halted, mem_err;
    logic [2:0] state_o;
`ifdef CORE_CTRL_PERF_EN
    logic [63:0] perf_cycles, perf_instret;
`endif

    always #5 clk = ~clk;

    core_ctrl_fsm #(.MEM_TIMEOUT(T)) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req       (ifu_req),
        .ifu_valid     (ifu_valid),
        .inst_we       (inst_we),
        .dec_mem_read  (dec_mem_read),
        .dec_mem_write (dec_mem_write),
        .dec_reg_write (dec_reg_write),
        .dec_ebreak    (dec_ebreak),
        .exu_en        (exu_en),
        .lsu_req       (lsu_req),
        .lsu_wen       (lsu_wen),
        .lsu_done      (lsu_done),
        .rf_we         (rf_we),
        .pc_we         (pc_we),
        .halted        (halted),
        .mem_err       (mem_err),
        .state_o       (state_o)
`ifdef CORE_CTRL_PERF_EN
        , .perf_cycles (perf_cycles),
        .perf_instret  (perf_instret)
`endif
    );

    // outs bit order: ifu_req inst_we exu_en lsu_req lsu_wen rf_we pc_we halted mem_err
    typedef struct {
        logic       ifu_valid, mr, mw, rw, eb, done;
        logic [2:0] st;
        logic [8:0] outs;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_wb  = 0;
    bit   absorbed;

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [8:0] act_outs();
        return {ifu_req, inst_we, exu_en, lsu_req, lsu_wen, rf_we, pc_we, halted, mem_err};
    endfunction

    task automatic push(input logic [2:0] st, input logic iv, mr, mw, rw, eb, dn,
                        input logic [8:0] outs);
        vec_t v;
        v.st = st; v.ifu_valid = iv; v.mr = mr; v.mw = mw; v.rw = rw; v.eb = eb;
        v.done = dn; v.outs = outs;
        vq.push_back(v);
    endtask

    // Expand one instruction. mwait<0: lsu_done never comes. ntail: cycles checked in HALT/ERR.
    task automatic gen(input int fw, input logic mr, mw, rw, eb, input int mwait, input int ntail);
        logic iv, dn;
        absorbed = 1'b0;
        for (int k = 0; k <= fw; k++) begin
            iv = (k == fw);
            push(3'd1, iv, rnd(), rnd(), rnd(), rnd(), rnd(), {1'b1, iv, 7'b0});
        end
        push(3'd2, rnd(), mr, mw, rw, eb, rnd(), 9'b0);
        push(3'd3, rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 9'b001000000);
        if (eb) begin
            for (int k = 0; k < ntail; k++)
                push(3'd6, rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 9'b000000010);
            absorbed = 1'b1;
            return;
        end
        if (mr || mw) begin
            for (int k = 0; ; k++) begin
                dn = (k == mwait);
                push(3'd4, rnd(), rnd(), rnd(), rnd(), rnd(), dn, {3'b000, 1'b1, mw, 4'b0});
                if (dn) break;
                if (k + 1 == T) begin
                    for (int j = 0; j < ntail; j++)
                        push(3'd7, rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 9'b000000001);
                    absorbed = 1'b1;
                    return;
                end
            end
        end
        push(3'd5, rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), {5'b0, rw, 1'b1, 2'b0});
        n_wb++;
    endtask

    task automatic run_trace(input string name);
        vec_t v;
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            @(negedge clk);
            ifu_valid     = v.ifu_valid;
            dec_mem_read  = v.mr;
            dec_mem_write = v.mw;
            dec_reg_write = v.rw;
            dec_ebreak    = v.eb;
            lsu_done      = v.done;
            #1;
            n_cmp++;
            if ({state_o, act_outs()} !== {v.st, v.outs}) begin
                n_bad++;
                $display("FAIL %s[%0d]: state/outs got %0d/%b expected %0d/%b",
                         name, i, state_o, act_outs(), v.st, v.outs);
            end
        end
        vq.delete();
    endtask

    // Asserts rst, checks outputs drop at once, then releases just after a rising edge.
    task automatic do_reset(input string name);
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({state_o, act_outs()} !== 12'b0) begin
            n_bad++;
            $display("FAIL %s: state/outs got %0d/%b expected 0/%b",
                     name, state_o, act_outs(), 9'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_wb = 0;
        push(3'd0, rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 9'b0);
    endtask

    initial begin
        ifu_valid = 0; dec_mem_read = 0; dec_mem_write = 0;
        dec_reg_write = 0; dec_ebreak = 0; lsu_done = 0;
        #1;
        do_reset("reset_init");

        gen(0, 0, 0, 1, 0, -1, 0);
        gen(0, 0, 0, 1, 0, -1, 0);
        run_trace("alu");
        gen(0, 1, 0, 1, 0, 3, 0);
        run_trace("load_wait3");
        gen(1, 0, 1, 0, 0, 0, 0);
        run_trace("store");
        gen(0, 1, 1, 1, 0, 1, 0);
        run_trace("rd_wr_as_store");
        gen(2, 0, 1, 1, 0, T - 1, 0);
        run_trace("done_at_limit");
        gen(0, 1, 0, 1, 0, -1, 6);
        run_trace("timeout");

        do_reset("reset_after_err");
        gen(2, 0, 0, 1, 1, -1, 6);
        run_trace("ebreak");

        do_reset("reset_after_halt");
        push(3'd1, 1'b1, rnd(), rnd(), rnd(), rnd(), rnd(), 9'b110000000);
        push(3'd2, rnd(), 1'b1, 1'b0, 1'b1, 1'b0, rnd(), 9'b0);
        push(3'd3, rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 9'b001000000);
        push(3'd4, rnd(), rnd(), rnd(), rnd(), rnd(), 1'b0, 9'b000100000);
        run_trace("pre_mid_rst");
        do_reset("mid_mem_reset");
        gen(0, 0, 0, 1, 0, -1, 0);
        run_trace("restart");

`ifdef CORE_CTRL_PERF_EN
        do_reset("reset_perf");
        n_cmp++;
        if (perf_instret !== 64'd0) begin
            n_bad++;
            $display("FAIL perf_instret_reset: got %0d expected 0", perf_instret);
        end
        for (int i = 0; i < 3; i++) gen(0, 0, 0, 1, 0, -1, 0);
        push(3'd1, 1'b0, rnd(), rnd(), rnd(), rnd(), rnd(), 9'b100000000);
        run_trace("perf_seq");
        n_cmp++;
        if (perf_instret !== 64'(n_wb)) begin
            n_bad++;
            $display("FAIL perf_instret_3: got %0d expected %0d", perf_instret, n_wb);
        end
`endif

        for (int r = 0; r < 30; r++) begin
            do_reset("reset_rand");
            for (int n = 0; n < 6; n++) begin
                gen($urandom_range(0, 2), rnd(), rnd(), rnd(), ($urandom_range(0, 7) == 0),
                    $urandom_range(0, 5), 3);
                if (absorbed) break;
            end
            run_trace("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
